// File: rtl/renkon_pkg.sv
// Shared constants and types for the renkon convolution datapath.
package renkon_pkg;

  localparam int DWIDTH = 16;
  localparam int MAXW   = 32;
  localparam int LWIDTH = $clog2(MAXW + 1);
  localparam int AWIDTH = $clog2(MAXW);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } win_state_t;

endpackage

// File: rtl/renkon_linebuf.sv
// One image row of delay: single-port RAM, read-before-write.
module renkon_linebuf
  import renkon_pkg::*;
(
  input  logic                     clk,
  input  logic                     en,
  input  logic [AWIDTH-1:0]        addr,
  input  logic signed [DWIDTH-1:0] din,
  output logic signed [DWIDTH-1:0] dout
);

  logic signed [DWIDTH-1:0] mem [MAXW];

  // Async read returns the previous row's pixel before this cycle's write.
  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/renkon_window5.sv
// 5x5 sliding-window generator: four line buffers feeding a register window.
module renkon_window5
  import renkon_pkg::*;
(
  input  logic                     clk,
  input  logic                     xrst,
  input  logic [LWIDTH-1:0]        img_size,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DWIDTH-1:0] in_pixel,
  output logic                     busy,
  output logic                     size_err,
  output logic                     win_valid,
  output logic signed [DWIDTH-1:0] win_pixel [25],
  output logic                     frame_done
);

  win_state_t state, state_n;

  logic [LWIDTH-1:0] size_q;
  logic [LWIDTH-1:0] col;
  logic [LWIDTH-1:0] row;

  logic accept;
  logic legal;
  logic last;
  logic launch;

  logic signed [DWIDTH-1:0] lb_dout [4];

  assign accept = (state == LOAD) && in_valid;
  assign legal  = (img_size >= LWIDTH'(5)) &&
                  (img_size <= LWIDTH'(MAXW));
  assign last   = (row == size_q - LWIDTH'(1)) &&
                  (col == size_q - LWIDTH'(1));
  assign launch = (state == IDLE) && start && legal;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (xrst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (launch)         state_n = LOAD;
      LOAD:    if (accept && last) state_n = FLUSH;
      FLUSH:                       state_n = IDLE;
      default:                     state_n = IDLE;
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_lb
      logic signed [DWIDTH-1:0] din;
      if (k == 0) begin : g_first
        assign din = in_pixel;
      end else begin : g_chain
        assign din = lb_dout[k-1];
      end
      renkon_linebuf u_lb (
        .clk  (clk),
        .en   (accept),
        .addr (col[AWIDTH-1:0]),
        .din  (din),
        .dout (lb_dout[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (xrst) begin
      size_q     <= '0;
      col        <= '0;
      row        <= '0;
      size_err   <= 1'b0;
      frame_done <= 1'b0;
      win_valid  <= 1'b0;
      for (int i = 0; i < 25; i++) win_pixel[i] <= '0;
    end else begin
      size_err   <= (state == IDLE) && start && !legal;
      frame_done <= (state == FLUSH);
      win_valid  <= accept && (row >= LWIDTH'(4)) &&
                    (col >= LWIDTH'(4));
      if (launch) begin
        size_q <= img_size;
        col    <= '0;
        row    <= '0;
        for (int i = 0; i < 25; i++) win_pixel[i] <= '0;
      end else if (accept) begin
        if (col == size_q - LWIDTH'(1)) begin
          col <= '0;
          row <= row + LWIDTH'(1);
        end else begin
          col <= col + LWIDTH'(1);
        end
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 4; c++)
            win_pixel[5*r+c] <= win_pixel[5*r+c+1];
        // Oldest row comes from the deepest line buffer.
        for (int r = 0; r < 4; r++)
          win_pixel[5*r+4] <= lb_dout[3-r];
        win_pixel[24] <= in_pixel;
      end
    end
  end

endmodule

// File: tb/tb_renkon_window5.sv
// Directed bench for renkon_window5 with an expected-window scoreboard.
module tb_renkon_window5;
  import renkon_pkg::*;

  localparam int WW = 25 * DWIDTH;

  logic                     clk = 1'b0;
  logic                     xrst;
  logic [LWIDTH-1:0]        img_size;
  logic                     start;
  logic                     in_valid;
  logic signed [DWIDTH-1:0] in_pixel;
  logic                     busy;
  logic                     size_err;
  logic                     win_valid;
  logic signed [DWIDTH-1:0] win_pixel [25];
  logic                     frame_done;

  int tests = 0;
  int fails = 0;

  logic [WW-1:0] exp_q [$];
  int            img [MAXW][MAXW];
  int            nwin;
  logic [WW-1:0] first_w, second_w, third_w, last_w;

  renkon_window5 dut (
    .clk        (clk),
    .xrst       (xrst),
    .img_size   (img_size),
    .start      (start),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .busy       (busy),
    .size_err   (size_err),
    .win_valid  (win_valid),
    .win_pixel  (win_pixel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] obs_win();
    logic [WW-1:0] w;
    for (int i = 0; i < 25; i++)
      w[i*DWIDTH +: DWIDTH] = win_pixel[i];
    return w;
  endfunction

  function automatic logic [31:0] wsel(logic [WW-1:0] w, int i);
    return 32'(w[i*DWIDTH +: DWIDTH]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(string tag, logic [WW-1:0] obs, logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(int size, bit gaps, bit midstart);
    logic [WW-1:0] e, w;
    bit            win;
    img_size = LWIDTH'(size);
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start", busy, 1);
    nwin = 0;
    for (int r = 0; r < size; r++) begin
      for (int c = 0; c < size; c++) begin
        in_valid  = 1'b1;
        in_pixel  = DWIDTH'(r * size + c);
        img[r][c] = r * size + c;
        if (midstart && r == 1 && c == 2) begin
          start    = 1'b1;
          img_size = LWIDTH'(6);
        end
        win = (r >= 4) && (c >= 4);
        if (win) begin
          for (int rr = 0; rr < 5; rr++)
            for (int cc = 0; cc < 5; cc++)
              e[(5*rr+cc)*DWIDTH +: DWIDTH] =
                DWIDTH'(img[r-4+rr][c-4+cc]);
          exp_q.push_back(e);
        end
        step();
        in_valid = 1'b0;
        start    = 1'b0;
        img_size = LWIDTH'(size);
        if (win) begin
          chk("win_valid", win_valid, 1);
          w = obs_win();
          e = exp_q.pop_front();
          chkw("win_pixel", w, e);
          if (nwin == 0) first_w = w;
          if (nwin == 1) second_w = w;
          if (nwin == 2) third_w = w;
          last_w = w;
          nwin++;
        end else begin
          chk("no_win", win_valid, 0);
        end
        if (gaps && !(r == size - 1 && c == size - 1))
          repeat (2) begin
            step();
            chk("gap_no_win", win_valid, 0);
          end
      end
    end
    chk("busy_flush", busy, 1);
    chk("done_early", frame_done, 0);
    step();
    chk("frame_done", frame_done, 1);
    chk("busy_drop", busy, 0);
    chk("win_after", win_valid, 0);
    step();
    chk("done_pulse", frame_done, 0);
    chk("nwin", nwin, (size - 4) * (size - 4));
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic bad_size(int size);
    img_size = LWIDTH'(size);
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("size_err", size_err, 1);
    chk("busy_bad", busy, 0);
    step();
    chk("size_err_pulse", size_err, 0);
    chk("busy_bad2", busy, 0);
  endtask

  initial begin
    xrst     = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    img_size = LWIDTH'(5);
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_size_err", size_err, 0);
    chk("rst_frame_done", frame_done, 0);
    chkw("rst_win_pixel", obs_win(), '0);
    xrst = 1'b0;
    step();

    run_frame(5, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) chk("f5_pix", wsel(last_w, i), i);

    run_frame(6, 1'b0, 1'b0);
    chk("f6_w0_0", wsel(first_w, 0), 0);
    chk("f6_w0_24", wsel(first_w, 24), 28);
    chk("f6_w1_0", wsel(second_w, 0), 1);
    chk("f6_w1_24", wsel(second_w, 24), 29);
    chk("f6_w2_0", wsel(third_w, 0), 6);
    chk("f6_w2_24", wsel(third_w, 24), 34);

    run_frame(6, 1'b1, 1'b0);
    chk("g6_w0_0", wsel(first_w, 0), 0);
    chk("g6_w0_24", wsel(first_w, 24), 28);
    chk("g6_w1_0", wsel(second_w, 0), 1);
    chk("g6_w2_24", wsel(third_w, 24), 34);
    chk("g6_w3_24", wsel(last_w, 24), 35);

    bad_size(4);
    bad_size(MAXW + 1);

    run_frame(MAXW, 1'b0, 1'b0);
    chk("max_last_24", wsel(last_w, 24), 1023);
    chk("max_last_0", wsel(last_w, 0), 891);

    img_size = LWIDTH'(5);
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_pixel = DWIDTH'(100 + i);
      step();
      chk("partial_no_win", win_valid, 0);
    end
    xrst  = 1'b1;
    start = 1'b1;
    step();
    xrst     = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_win_valid", win_valid, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chkw("mid_rst_win_pixel", obs_win(), '0);
    step();
    chk("rst_beats_start", busy, 0);

    run_frame(5, 1'b0, 1'b0);
    chk("after_rst_0", wsel(last_w, 0), 0);
    chk("after_rst_24", wsel(last_w, 24), 24);

    run_frame(5, 1'b0, 1'b1);
    chk("midstart_12", wsel(last_w, 12), 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
